// File: rtl/serial_sched.sv
// Serial datapath scheduler: round-robin arbitration between two requesters,
// then sequences the load/add/multiply phases that drive the bit-serial enables.
module serial_sched #(
    parameter int WIDTH = 8,
    parameter int ALIGN = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [1:0]               i_req,
    input  logic [1:0]               i_op0,
    input  logic [1:0]               i_op1,
    output logic [1:0]               o_gnt,
    output logic [1:0]               o_done,
    output logic                     o_busy,
    output logic [$clog2(WIDTH)-1:0] o_bit,
    output logic                     o_mux,
    output logic                     o_muxalu,
    output logic                     o_gpr_shift,
    output logic                     o_gpr_write,
    output logic                     o_acc_shift,
    output logic                     o_acc_write
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_W = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_A = BW'(ALIGN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ADD, MREAD, MALIGN, MMUL, RSVD} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          phase_last;
    logic          pick;
    logic [1:0]    sel_op;

    assign phase_last = (state_q == RSVD) ||
                        ((state_q == MALIGN) ? (cnt_q == LAST_A) : (cnt_q == LAST_W));

    // last_q holds the most recently served requester; resetting it to 1 favours requester 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q + BW'(1);
        pick    = (i_req == 2'b11) ? ~last_q : i_req[1];
        sel_op  = pick ? i_op1 : i_op0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_req != 2'b00) begin
                    gnt_d  = pick ? 2'b10 : 2'b01;
                    last_d = pick;
                    case (sel_op)
                        2'b00:   state_d = LOAD;
                        2'b01:   state_d = ADD;
                        2'b10:   state_d = MREAD;
                        default: state_d = RSVD;
                    endcase
                end
            end
            MREAD: begin
                if (phase_last) begin
                    state_d = MALIGN;
                    cnt_d   = '0;
                end
            end
            MALIGN: begin
                if (phase_last) begin
                    state_d = MMUL;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (phase_last) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Enables depend only on registered state and counter, never on i_req
    always_comb begin
        o_mux       = 1'b0;
        o_muxalu    = 1'b0;
        o_gpr_shift = 1'b0;
        o_gpr_write = 1'b0;
        o_acc_shift = 1'b0;
        o_acc_write = 1'b0;
        o_done      = 2'b00;
        case (state_q)
            LOAD: begin
                o_mux       = 1'b1;
                o_gpr_shift = 1'b1;
                o_gpr_write = 1'b1;
            end
            ADD: begin
                o_gpr_shift = 1'b1;
                o_gpr_write = 1'b1;
                o_acc_shift = 1'b1;
            end
            MREAD: begin
                o_muxalu    = 1'b1;
                o_gpr_shift = 1'b1;
                o_gpr_write = 1'b1;
                o_acc_shift = 1'b1;
                o_acc_write = 1'b1;
            end
            MALIGN: o_acc_shift = 1'b1;
            MMUL: begin
                o_gpr_shift = 1'b1;
                o_gpr_write = 1'b1;
                o_acc_shift = 1'b1;
                o_acc_write = 1'b1;
            end
            default: ;
        endcase
        if (phase_last && (state_q inside {LOAD, ADD, MMUL, RSVD}))
            o_done = gnt_q;
    end

    assign o_gnt  = gnt_q;
    assign o_busy = |gnt_q;
    assign o_bit  = cnt_q;

endmodule

// File: tb/tb_serial_sched.sv
// Bench for serial_sched: a phase-script model predicts every output each cycle;
// directed scenarios add explicit timing checks, then a randomized run.
module tb_serial_sched;

    localparam int W = 8;
    localparam int A = 4;

    localparam logic [5:0] EN_LOAD   = 6'b101100;
    localparam logic [5:0] EN_ADD    = 6'b001110;
    localparam logic [5:0] EN_MREAD  = 6'b011111;
    localparam logic [5:0] EN_MALIGN = 6'b000010;
    localparam logic [5:0] EN_MMUL   = 6'b001111;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, op0, op1;
    logic [1:0] o_gnt, o_done;
    logic       o_busy;
    logic [2:0] o_bit;
    logic       o_mux, o_muxalu, o_gpr_shift, o_gpr_write, o_acc_shift, o_acc_write;

    always #5 clk = ~clk;

    serial_sched #(.WIDTH(W), .ALIGN(A)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_op0(op0), .i_op1(op1),
        .o_gnt(o_gnt), .o_done(o_done), .o_busy(o_busy), .o_bit(o_bit),
        .o_mux(o_mux), .o_muxalu(o_muxalu), .o_gpr_shift(o_gpr_shift),
        .o_gpr_write(o_gpr_write), .o_acc_shift(o_acc_shift), .o_acc_write(o_acc_write)
    );

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] done;
        logic [2:0] bitv;
        logic [5:0] en;
    } rec_t;

    rec_t        q[$];
    logic        last_served;
    bit          prev_idle;
    logic [13:0] exp_v;
    logic        s_rst;
    logic [1:0]  s_req, s_op0, s_op1;
    int          checks = 0;
    int          passes = 0;

    function automatic logic [13:0] obs();
        return {o_gnt, o_done, o_busy, o_bit,
                o_mux, o_muxalu, o_gpr_shift, o_gpr_write, o_acc_shift, o_acc_write};
    endfunction

    task automatic push_phase(input logic [1:0] g, input int len, input logic [5:0] en,
                              input bit final_phase);
        for (int i = 0; i < len; i++) begin
            rec_t r;
            r.gnt  = g;
            r.done = (final_phase && i == len - 1) ? g : 2'b00;
            r.bitv = 3'(i);
            r.en   = en;
            q.push_back(r);
        end
    endtask

    // Advance one clock; the model consumes the inputs that the edge sampled
    task automatic step();
        logic       pick;
        logic [1:0] g, op;
        rec_t       r;
        s_rst = rst; s_req = req; s_op0 = op0; s_op1 = op1;
        @(posedge clk);
        #1;
        if (s_rst) begin
            q.delete();
            last_served = 1'b1;
            prev_idle   = 1'b1;
            exp_v       = '0;
        end else begin
            if (q.size() == 0 && prev_idle && s_req != 2'b00) begin
                pick = (s_req == 2'b11) ? ~last_served : s_req[1];
                last_served = pick;
                g  = pick ? 2'b10 : 2'b01;
                op = pick ? s_op1 : s_op0;
                case (op)
                    2'b00: push_phase(g, W, EN_LOAD, 1'b1);
                    2'b01: push_phase(g, W, EN_ADD, 1'b1);
                    2'b10: begin
                        push_phase(g, W, EN_MREAD, 1'b0);
                        push_phase(g, A, EN_MALIGN, 1'b0);
                        push_phase(g, W, EN_MMUL, 1'b1);
                    end
                    default: push_phase(g, 1, 6'b000000, 1'b1);
                endcase
            end
            if (q.size() > 0) begin
                r = q.pop_front();
                exp_v = {r.gnt, r.done, 1'b1, r.bitv, r.en};
                prev_idle = 1'b0;
            end else begin
                exp_v = '0;
                prev_idle = 1'b1;
            end
        end
    endtask

    task automatic settle();
        req = 2'b00;
        repeat (2 * W + A + 2) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; op0 = 2'b01; op1 = 2'b10;
        repeat (3) begin
            step();
            checks++;
            if (obs() !== 14'd0) $display("[TB] FAIL reset_hold: got %h expected %h", obs(), 14'd0);
            else passes++;
        end
        rst = 1'b0; req = 2'b00;
        step();
        checks++;
        if (obs() !== exp_v) $display("[TB] FAIL reset_release: got %h expected %h", obs(), exp_v);
        else passes++;
    endtask

    task automatic test_load();
        int done_bit = -1;
        req = 2'b01; op0 = 2'b00; op1 = 2'b10;
        for (int n = 0; n < W; n++) begin
            step();
            if (n == 0) begin
                req = 2'b00;
                checks++;
                if ({o_gnt, o_mux, o_gpr_write, o_gpr_shift} !== 5'b01111)
                    $display("[TB] FAIL load_grant: got %b expected %b",
                             {o_gnt, o_mux, o_gpr_write, o_gpr_shift}, 5'b01111);
                else passes++;
            end
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL load_cycle: got %h expected %h", obs(), exp_v);
            else passes++;
            if (o_done !== 2'b00) done_bit = int'(o_bit);
        end
        checks++;
        if (done_bit != W - 1) $display("[TB] FAIL load_done_bit: got %0d expected %0d", done_bit, W - 1);
        else passes++;
        step();
        checks++;
        if (obs() !== 14'd0) $display("[TB] FAIL load_idle_after: got %h expected %h", obs(), 14'd0);
        else passes++;
    endtask

    task automatic test_multiply();
        int done_at = 0;
        req = 2'b10; op1 = 2'b10; op0 = 2'b00;
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            step();
            if (n == 1) req = 2'b00;
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL mul_cycle: got %h expected %h", obs(), exp_v);
            else passes++;
            if (o_done !== 2'b00) done_at = n;
        end
        checks++;
        if (done_at != 2 * W + A) $display("[TB] FAIL mul_done_cycle: got %0d expected %0d", done_at, 2 * W + A);
        else passes++;
        checks++;
        if (o_done !== 2'b10) $display("[TB] FAIL mul_done_bit: got %b expected %b", o_done, 2'b10);
        else passes++;
        step();
        checks++;
        if (obs() !== exp_v) $display("[TB] FAIL mul_idle_after: got %h expected %h", obs(), exp_v);
        else passes++;
    endtask

    task automatic test_round_robin();
        logic [1:0] grants[3];
        int         gaps[2];
        int         ng = 0;
        int         idle_run = 0;
        logic [1:0] prev_gnt = 2'b00;
        grants = '{2'b00, 2'b00, 2'b00};
        gaps = '{-1, -1};
        req = 2'b11; op0 = 2'b01; op1 = 2'b01;
        for (int n = 0; n < 80 && ng < 3; n++) begin
            step();
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL rr_cycle: got %h expected %h", obs(), exp_v);
            else passes++;
            if (o_gnt !== 2'b00 && prev_gnt === 2'b00) begin
                if (ng > 0) gaps[ng - 1] = idle_run;
                grants[ng] = o_gnt;
                ng++;
            end
            if (o_gnt === 2'b00) idle_run++;
            else idle_run = 0;
            prev_gnt = o_gnt;
        end
        checks++;
        if (grants[0] !== 2'b01 || grants[1] !== 2'b10 || grants[2] !== 2'b01)
            $display("[TB] FAIL rr_order: got %b %b %b expected 01 10 01", grants[0], grants[1], grants[2]);
        else passes++;
        checks++;
        if (gaps[0] != 1 || gaps[1] != 1)
            $display("[TB] FAIL rr_gap: got %0d %0d expected 1 1", gaps[0], gaps[1]);
        else passes++;
        settle();
    endtask

    task automatic test_no_abort();
        bit found = 0;
        bit done_seen = 0;
        req = 2'b01; op0 = 2'b01;
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL noabort_pre: got %h expected %h", obs(), exp_v);
            else passes++;
            if (o_gnt === 2'b01 && o_bit === 3'd3) begin found = 1; break; end
        end
        req = 2'b00; op0 = 2'b10;
        for (int n = 0; n < 10 && found; n++) begin
            step();
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL noabort_cycle: got %h expected %h", obs(), exp_v);
            else passes++;
            if (o_done !== 2'b00) begin
                done_seen = 1;
                checks++;
                if ({o_bit, o_gpr_write, o_gpr_shift, o_acc_shift, o_muxalu} !== 7'b111_1110)
                    $display("[TB] FAIL noabort_done: got %b expected %b",
                             {o_bit, o_gpr_write, o_gpr_shift, o_acc_shift, o_muxalu}, 7'b111_1110);
                else passes++;
                break;
            end
        end
        checks++;
        if (!(found && done_seen)) $display("[TB] FAIL noabort_timeout: got %0d%0d expected 11", found, done_seen);
        else passes++;
        settle();
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        req = 2'b10; op1 = 2'b10;
        for (int n = 0; n < 40; n++) begin
            step();
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL rstmid_pre: got %h expected %h", obs(), exp_v);
            else passes++;
            if (o_acc_shift === 1'b1 && o_gpr_shift === 1'b0 && o_bit === 3'd2 && o_gnt === 2'b10) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) $display("[TB] FAIL rstmid_timeout: got %0d expected 1", found);
        else passes++;
        rst = 1'b1; req = 2'b00;
        step();
        checks++;
        if (obs() !== 14'd0) $display("[TB] FAIL rstmid_clear: got %h expected %h", obs(), 14'd0);
        else passes++;
        rst = 1'b0; req = 2'b11; op0 = 2'b01; op1 = 2'b01;
        step();
        checks++;
        if (o_gnt !== 2'b01) $display("[TB] FAIL rstmid_regrant: got %b expected %b", o_gnt, 2'b01);
        else passes++;
        checks++;
        if (obs() !== exp_v) $display("[TB] FAIL rstmid_model: got %h expected %h", obs(), exp_v);
        else passes++;
        settle();
    endtask

    task automatic test_reserved();
        req = 2'b01; op0 = 2'b11;
        step();
        req = 2'b00;
        checks++;
        if (obs() !== 14'b01_01_1_000_000000)
            $display("[TB] FAIL rsvd_cycle: got %h expected %h", obs(), 14'b01_01_1_000_000000);
        else passes++;
        step();
        checks++;
        if (obs() !== 14'd0) $display("[TB] FAIL rsvd_idle_after: got %h expected %h", obs(), 14'd0);
        else passes++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            op0 = 2'($urandom_range(0, 3));
            op1 = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (obs() !== exp_v) $display("[TB] FAIL random_cycle %0d: got %h expected %h", n, obs(), exp_v);
            else passes++;
        end
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00;
        last_served = 1'b1;
        prev_idle = 1'b1;
        exp_v = '0;
        test_reset();
        test_load();
        test_multiply();
        test_round_robin();
        test_no_abort();
        test_reset_mid();
        test_reserved();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_sched.md
SERIAL_SCHED -- requirements
Module: serial_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the serial word length in bits (bit-cycles per pass).
REQ-002 The block SHALL have parameter ALIGN, default 4, giving the multiply alignment phase length in cycles.
REQ-003 The block SHALL use one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-004 i_clk  input  1  clock; all state changes on the rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_req  input  2  per-requester level request; bit n belongs to requester n.
REQ-007 i_op0  input  2  op code of requester 0: 00 load, 01 add, 10 multiply, 11 reserved.
REQ-008 i_op1  input  2  op code of requester 1, same encoding.
REQ-009 o_gnt  output  2  one-hot grant, held for the whole operation.
REQ-010 o_done  output  2  one-cycle pulse on the granted bit during the final operation cycle.
REQ-011 o_busy  output  1  high whenever o_gnt is non-zero.
REQ-012 o_bit  output  clog2(WIDTH)  bit index within the current phase.
REQ-013 o_mux, o_muxalu, o_gpr_shift, o_gpr_write, o_acc_shift, o_acc_write  output  1 each  datapath enables.

Function
REQ-014 States SHALL be IDLE, LOAD, ADD, MREAD, MALIGN, MMUL and RSVD.
REQ-015 In IDLE with any i_req bit set, the block SHALL register a grant, so o_gnt rises the next cycle; the op code is sampled in that same IDLE cycle and held until done.
REQ-016 Arbitration SHALL be round-robin: if both requesters request, grant the one not most recently served; the pointer after reset favours requester 0.
REQ-017 If only one requester requests, it SHALL be granted regardless of the pointer.
REQ-018 The pointer SHALL update to the granted requester when the grant is issued.
REQ-019 LOAD SHALL last WIDTH cycles with o_mux, o_gpr_write and o_gpr_shift high.
REQ-020 ADD SHALL last WIDTH cycles with o_gpr_write, o_gpr_shift and o_acc_shift high; o_muxalu stays 0.
REQ-021 Multiply SHALL run three phases, MREAD, MALIGN and MMUL, for a total of 2*WIDTH+ALIGN cycles.
REQ-022 MREAD SHALL last WIDTH cycles with o_muxalu, o_gpr_shift, o_gpr_write, o_acc_shift and o_acc_write high.
REQ-023 MALIGN SHALL last ALIGN cycles with only o_acc_shift high.
REQ-024 MMUL SHALL last WIDTH cycles with o_gpr_shift, o_gpr_write, o_acc_shift and o_acc_write high.
REQ-025 RSVD SHALL last 1 cycle with all enables low, then assert o_done.
REQ-026 o_bit SHALL count 0..WIDTH-1 in LOAD, ADD, MREAD and MMUL, and 0..ALIGN-1 in MALIGN.
REQ-027 o_bit SHALL reset to 0 at each phase entry and SHALL be 0 in IDLE.
REQ-028 o_done SHALL be high when o_bit equals the last index of the final phase.
REQ-029 The state SHALL return to IDLE on the cycle after o_done, giving exactly one IDLE cycle between back-to-back operations.
REQ-030 Deassertion of the granted i_req mid-operation SHALL NOT abort or alter the operation.
REQ-031 Changes to i_op0 or i_op1 after sampling SHALL be ignored.
REQ-032 A requester still requesting in the IDLE cycle after its o_done SHALL be treated as a new request.
REQ-033 In IDLE all enables and o_busy SHALL be 0.
REQ-034 Enables SHALL be driven only from registered state and counter, so they carry no combinational path from i_req.

Reset
REQ-035 While i_rst is high, the state SHALL be IDLE, o_gnt=00, o_done=00, o_busy=0, o_bit=0, all enables 0, and the pointer set to favour requester 0.
REQ-036 i_rst asserted mid-operation SHALL abort it on the next edge, with no o_done pulse issued.

Verification
REQ-037 Scenario: reset, then i_req=01 with i_op0=00 -> o_gnt=01 one cycle later; o_mux, o_gpr_write and o_gpr_shift high for 8 cycles with o_bit 0..7; o_done=01 at o_bit=7; IDLE next cycle.
REQ-038 Scenario: i_req=10 with i_op1=10 -> MREAD 8, MALIGN 4 (o_bit 0..3, only o_acc_shift), MMUL 8; o_done=10 on cycle 20 after grant.
REQ-039 Scenario: i_req=11 held, both ops add -> grants alternate 01, 10, 01 with 8-cycle operations separated by one IDLE cycle each.
REQ-040 Scenario: during an ADD grant, drop i_req and change i_op0 to 10 at o_bit=3 -> ADD completes unchanged; o_done at o_bit=7.
REQ-041 Scenario: i_rst pulsed during MALIGN at o_bit=2 -> all outputs 0 next cycle, no o_done pulse; a subsequent i_req=11 grants requester 0.
REQ-042 Scenario: i_op0=11 requested -> one grant cycle with o_done=01 and all enables 0.
